// File: rtl/block_control_rr.sv
// Round-robin channel arbiter: picks which FIFO channel feeds the next packet (code 0 = empty packet).
// Define BLOCK_CONTROL_RR_SKIP_EN for work-conserving mode (grant first ready channel from ptr onward).
module block_control_rr #(
  parameter int N_CH   = 3,
  parameter int CNT_W  = 8,
  parameter int THRESH = 30,
  parameter int CODE_W = 2,
  parameter int STAT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    next,
  input  logic [N_CH*CNT_W-1:0]   fifo_cnt,
  output logic [CODE_W-1:0]       rdy_cnl,
  output logic                    cnl_vld,
  output logic [STAT_W-1:0]       empty_cnt
);

  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic {ST_ARB, ST_WT} state_t;

  state_t              state, state_nxt;
  logic [PTR_W-1:0]    ptr, ptr_nxt;
  logic [CODE_W-1:0]   code, code_nxt;
  logic                vld_nxt;
  logic [STAT_W-1:0]   empty_nxt;
  logic [N_CH-1:0]     rdy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == N_CH - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rdy = '0;
    for (int i = 0; i < N_CH; i++)
      rdy[i] = 32'(fifo_cnt[i*CNT_W +: CNT_W]) >= 32'(THRESH);
  end

`ifdef BLOCK_CONTROL_RR_SKIP_EN
  logic [PTR_W-1:0] last_grant, grant, grant_nxt;
  logic             found;
  int               idx;

  // Scan channels starting at ptr; the first ready one wins.
  always_comb begin
    code  = '0;
    grant = ptr;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(ptr) + k) % N_CH;
      if (!found && rdy[idx]) begin
        found = 1'b1;
        grant = PTR_W'(idx);
        code  = CODE_W'(idx + 1);
      end
    end
  end
`else
  always_comb begin
    code = rdy[ptr] ? CODE_W'(int'(ptr) + 1) : '0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ARB;
      ptr       <= '0;
      rdy_cnl   <= '0;
      cnl_vld   <= 1'b0;
      empty_cnt <= '0;
`ifdef BLOCK_CONTROL_RR_SKIP_EN
      last_grant <= '0;
`endif
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      rdy_cnl   <= code_nxt;
      cnl_vld   <= vld_nxt;
      empty_cnt <= empty_nxt;
`ifdef BLOCK_CONTROL_RR_SKIP_EN
      last_grant <= grant_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARB:  state_nxt = ST_WT;
      ST_WT:   if (next) state_nxt = ST_ARB;
      default: state_nxt = ST_ARB;
    endcase
  end

  always_comb begin
    ptr_nxt   = ptr;
    code_nxt  = rdy_cnl;
    vld_nxt   = cnl_vld;
    empty_nxt = empty_cnt;
`ifdef BLOCK_CONTROL_RR_SKIP_EN
    grant_nxt = last_grant;
`endif
    case (state)
      ST_ARB: begin
        code_nxt = code;
        vld_nxt  = 1'b1;
        if (code == '0 && empty_cnt != '1)
          empty_nxt = empty_cnt + 1'b1;
`ifdef BLOCK_CONTROL_RR_SKIP_EN
        grant_nxt = grant;
`endif
      end
      ST_WT: begin
        if (next) begin
          vld_nxt = 1'b0;
`ifdef BLOCK_CONTROL_RR_SKIP_EN
          // Resume the rotation just past whoever was served last.
          ptr_nxt = (rdy_cnl != '0) ? ptr_inc(last_grant) : ptr_inc(ptr);
`else
          ptr_nxt = ptr_inc(ptr);
`endif
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_block_control_rr.sv
// Self-checking bench for block_control_rr: directed test-plan cases plus randomized traffic vs a slot-level model.
module tb_block_control_rr;

  localparam int N_CH = 3;
  localparam int CNT_W = 8;
  localparam int THRESH = 30;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  next;
  logic [N_CH*CNT_W-1:0] fifo_cnt;
  logic [1:0]            rdy_cnl, rdy_cnl_s;
  logic                  cnl_vld, cnl_vld_s;
  logic [15:0]           empty_cnt;
  logic [3:0]            empty_cnt_s;

  int num_cmp = 0;
  int num_err = 0;
  int cnt[N_CH];
  int m_ptr, m_empty, m_code;

  always #5 clk = ~clk;

  block_control_rr dut (
    .clk(clk), .rst_n(rst_n), .next(next), .fifo_cnt(fifo_cnt),
    .rdy_cnl(rdy_cnl), .cnl_vld(cnl_vld), .empty_cnt(empty_cnt)
  );

  block_control_rr #(.STAT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .next(next), .fifo_cnt(fifo_cnt),
    .rdy_cnl(rdy_cnl_s), .cnl_vld(cnl_vld_s), .empty_cnt(empty_cnt_s)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    num_cmp++;
    if (actual != expected) begin
      num_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic logic [N_CH*CNT_W-1:0] packCounts();
    logic [N_CH*CNT_W-1:0] v;
    v = '0;
    for (int i = 0; i < N_CH; i++) v[i*CNT_W +: CNT_W] = CNT_W'(cnt[i]);
    return v;
  endfunction

  // Expected code for the slot the model pointer currently names.
  function automatic int modelCode();
`ifdef BLOCK_CONTROL_RR_SKIP_EN
    for (int k = 0; k < N_CH; k++)
      if (cnt[(m_ptr + k) % N_CH] >= THRESH) return ((m_ptr + k) % N_CH) + 1;
    return 0;
`else
    return (cnt[m_ptr] >= THRESH) ? m_ptr + 1 : 0;
`endif
  endfunction

  task automatic modelAdvance();
`ifdef BLOCK_CONTROL_RR_SKIP_EN
    m_ptr = (m_code != 0) ? m_code % N_CH : (m_ptr + 1) % N_CH;
`else
    m_ptr = (m_ptr + 1) % N_CH;
`endif
  endtask

  task automatic checkDecision(input string tag);
    m_code = modelCode();
    if (m_code == 0) m_empty++;
    checkOutput({tag, "_vld"}, int'(cnl_vld), 1);
    checkOutput({tag, "_code"}, int'(rdy_cnl), m_code);
    checkOutput({tag, "_code_s"}, int'(rdy_cnl_s), m_code);
    checkOutput({tag, "_empty"}, int'(empty_cnt), (m_empty > 65535) ? 65535 : m_empty);
    checkOutput({tag, "_empty_s"}, int'(empty_cnt_s), (m_empty > 15) ? 15 : m_empty);
  endtask

  task automatic resetDut(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    next = 1'b0;
    #1;
    checkOutput({tag, "_rst_code"}, int'(rdy_cnl), 0);
    checkOutput({tag, "_rst_vld"}, int'(cnl_vld), 0);
    checkOutput({tag, "_rst_empty"}, int'(empty_cnt), 0);
    m_ptr = 0;
    m_empty = 0;
    @(negedge clk);
    fifo_cnt = packCounts();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkDecision({tag, "_first"});
  endtask

  // One packet: optional idle hold (with noisy counts), then next, gap cycle, new decision.
  task automatic applyStimulus(input string tag, input int hold, input bit keep);
    repeat (hold) begin
      @(negedge clk);
      next = 1'b0;
      fifo_cnt = (N_CH*CNT_W)'($urandom);
      @(posedge clk);
      #1;
      checkOutput({tag, "_hold_code"}, int'(rdy_cnl), m_code);
      checkOutput({tag, "_hold_vld"}, int'(cnl_vld), 1);
    end
    @(negedge clk);
    next = 1'b1;
    fifo_cnt = packCounts();
    @(posedge clk);
    #1;
    checkOutput({tag, "_gap_vld"}, int'(cnl_vld), 0);
    modelAdvance();
    @(negedge clk);
    next = keep;
    @(posedge clk);
    #1;
    checkDecision(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    next = 1'b0;
    fifo_cnt = '0;
    m_code = 0;

    $display("[TB] all-empty channels");
    cnt = '{0, 0, 0};
    resetDut("t1");
    for (int i = 0; i < 4; i++) applyStimulus("t1", 1, 1'b0);
    checkOutput("t1_total_empty", int'(empty_cnt), 5);

    $display("[TB] all channels ready");
    cnt = '{40, 40, 40};
    resetDut("t2");
    for (int i = 0; i < 4; i++) applyStimulus("t2", 2, 1'b0);

    $display("[TB] threshold boundary");
    cnt = '{29, 0, 0};
    resetDut("t3_29");
    cnt = '{30, 0, 0};
    resetDut("t3_30");

    $display("[TB] single ready channel");
    cnt = '{0, 0, 50};
    resetDut("t4");
    for (int i = 0; i < 5; i++) applyStimulus("t4", 0, 1'b1);

    $display("[TB] reset while waiting");
    cnt = '{40, 40, 40};
    resetDut("t5");
    applyStimulus("t5", 1, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_async_code", int'(rdy_cnl), 0);
    checkOutput("t5_async_vld", int'(cnl_vld), 0);
    resetDut("t5_after");

    $display("[TB] empty counter saturation");
    cnt = '{0, 0, 0};
    resetDut("t6");
    for (int i = 0; i < 20; i++) applyStimulus("t6", 0, 1'($urandom_range(0, 1)));
    checkOutput("t6_sat", int'(empty_cnt_s), 15);
    checkOutput("t6_wide", int'(empty_cnt), 21);

    $display("[TB] randomized traffic");
    for (int i = 0; i < N_CH; i++) cnt[i] = $urandom_range(20, 45);
    resetDut("rnd");
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < N_CH; i++) cnt[i] = $urandom_range(20, 45);
      applyStimulus("rnd", $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_err);
    $finish;
  end

endmodule

// File: doc/block_control_rr.md
Name: block_control_rr

Overview:
- Parametrised round-robin arbiter that selects which input FIFO channel feeds the next outgoing packet.
- Sits between the N_CH channel FIFOs and the packet former. Reads FIFO fill counts and issues a channel code; code 0 means an empty packet.
- Adds over the previous fixed 3-channel arbiter: configurable channel count, width and threshold; a valid flag; an async reset; an empty-packet statistic; and an optional work-conserving mode.

Parameters:
- N_CH, 3: number of input channels (1..15).
- CNT_W, 8: width of each FIFO fill count.
- THRESH, 30: channel is ready when its fill count >= THRESH (unsigned compare).
- CODE_W, 2: width of channel code; must satisfy 2^CODE_W >= N_CH+1.
- STAT_W, 16: width of the empty-packet counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- next  in  1  packet former done with the current packet; request the next decision.
- fifo_cnt  in  N_CH*CNT_W  packed fill counts; channel i occupies bits [i*CNT_W +: CNT_W].
- rdy_cnl  out  CODE_W  granted code: 0 = empty packet, i+1 = channel i.
- cnl_vld  out  1  rdy_cnl holds a fresh, stable decision.
- empty_cnt  out  STAT_W  saturating count of code-0 decisions issued.

Behaviour:
- Reset (rst_n=0, any time, including mid-packet):
  - st=ST_ARB, ptr=0, rdy_cnl=0, cnl_vld=0, empty_cnt=0, last_grant=0.
  - Outputs change immediately and asynchronously.
- Ready vector: rdy[i] = (fifo_cnt slice i >= THRESH). This is combinational from registered inputs.
- States:
  - ST_ARB, one cycle: compute the decision, register it into rdy_cnl, set cnl_vld<=1, go to ST_WT. next is ignored in this state.
  - ST_WT: hold rdy_cnl and cnl_vld. On next=1: cnl_vld<=0, update ptr, go to ST_ARB. With next=0 the block stays in ST_WT indefinitely.
- Decision (strict mode, default):
  - If rdy[ptr]: rdy_cnl<=ptr+1.
  - Else: rdy_cnl<=0.
- Pointer update on next:
  - Strict mode: ptr<=ptr+1, wrapping from N_CH-1 to 0.
- Latency:
  - After reset release, first cnl_vld=1 at the 1st rising edge.
  - next sampled high at edge k gives new rdy_cnl with cnl_vld=1 at edge k+1. cnl_vld is low for exactly one cycle between decisions.
- empty_cnt: increments by 1 on each ST_ARB cycle that issues code 0. It holds at all-ones (no wrap).
- fifo_cnt changes during ST_WT have no effect on the held decision.
- next held high continuously gives one decision every 2 cycles.
- N_CH=1: ptr stays 0.

Optional Feature:
- Macro: BLOCK_CONTROL_RR_SKIP_EN.
- Defined (work-conserving mode):
  - ST_ARB grants the first ready channel searching ptr, ptr+1, ... modulo N_CH.
  - The grant is recorded in last_grant.
  - Code 0 is issued only when no channel is ready.
  - On next: ptr<=last_grant+1 (mod N_CH) if the code was nonzero, else ptr<=ptr+1 (mod N_CH).
- Undefined: strict slot behaviour as above. No search logic is synthesised.

Test Plan:
- Reset, N_CH=3, all counts 0, next pulsed 4 times: rdy_cnl sequence 0,0,0,0,0 (initial decision plus one per pulse), cnl_vld low 1 cycle after each next, empty_cnt=5.
- Counts {40,40,40}, next every 4 cycles: rdy_cnl 1,2,3,1,2; empty_cnt stays 0.
- Boundary: ch0 count 29 then 30, strict mode, ptr=0: code 0 at 29, code 1 at 30.
- Strict mode, counts {0,0,50}: sequence 0,0,3,0,0,3. Same stimulus with SKIP_EN: sequence 3,3,3.
- rst_n asserted low while in ST_WT with rdy_cnl=2: rdy_cnl=0 and cnl_vld=0 without a clock edge. After release, the first decision is for channel 0.
- STAT_W=4, all counts 0, 20 next pulses: empty_cnt saturates at 15.
